// File: rtl/cdb_arbiter_pkg.sv
// Shared out-of-order core constants: bus arbiter sizing and result-bus tag width.
package cdb_arbiter_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int TAG_WIDTH = 6;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/permit bundle between the output buffers and the shared-bus arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int IDX_WIDTH = idx_width(N_REQ)
) ();
  logic [N_REQ-1:0]     request;
  logic                 bus_stall;
  logic [N_REQ-1:0]     permit;
  logic                 bus_valid;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic [IDX_WIDTH-1:0] priority_ptr;

  modport master (
    input  request, bus_stall,
    output permit, bus_valid, grant_idx, priority_ptr
  );
  modport slave (
    output request, bus_stall,
    input  permit, bus_valid, grant_idx, priority_ptr
  );
endinterface

// File: rtl/cdb_arbiter_rotating_priority_encoder.sv
// Combinational round-robin scan: first set request at ptr, ptr+1, ... wrapping at N_REQ.
module rotating_priority_encoder
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int IDX_WIDTH = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0]     request,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [N_REQ-1:0]     grant,
  output logic [IDX_WIDTH-1:0] index,
  output logic                 valid
);
  localparam logic [IDX_WIDTH:0] NR = (IDX_WIDTH+1)'(N_REQ);

  logic [IDX_WIDTH:0] w_pos;

  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    w_pos = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = {1'b0, ptr} + (IDX_WIDTH+1)'(k);
      if (w_pos >= NR) w_pos = w_pos - NR;
      // Only the first hit in scan order wins, keeping grant one-hot.
      if (!valid && request[w_pos[IDX_WIDTH-1:0]]) begin
        valid = 1'b1;
        index = w_pos[IDX_WIDTH-1:0];
        grant = N_REQ'(1) << w_pos[IDX_WIDTH-1:0];
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Zero-latency round-robin arbiter for a shared result/address bus; state is only the pointer.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int IDX_WIDTH = idx_width(N_REQ)
) (
  input  logic          clk,
  input  logic          reset,
  cdb_arbiter_if.master bus
);
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(N_REQ - 1);

  logic [IDX_WIDTH-1:0] r_ptr;
  logic [N_REQ-1:0]     w_grant;
  logic [IDX_WIDTH-1:0] w_idx;
  logic                 w_any;
  logic                 w_en;

  rotating_priority_encoder #(.N_REQ(N_REQ), .IDX_WIDTH(IDX_WIDTH)) u_rpe (
    .request (bus.request),
    .ptr     (r_ptr),
    .grant   (w_grant),
    .index   (w_idx),
    .valid   (w_any)
  );

  // Reset is folded into the gate so an in-flight permit drops without a clock edge.
  assign w_en             = reset & ~bus.bus_stall & w_any;
  assign bus.permit       = w_en ? w_grant : '0;
  assign bus.bus_valid    = w_en;
  assign bus.grant_idx    = w_en ? w_idx : '0;
  assign bus.priority_ptr = r_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_ptr <= '0;
    else if (w_en) r_ptr <= (w_idx == LAST) ? '0 : w_idx + IDX_WIDTH'(1);
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of functional-unit output buffers sharing one data bus (the CDB or the address bus); legal range 2..16.
REQ-002 Parameter IDX_WIDTH, default $clog2(N_REQ), width of the grant index.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 request  input  N_REQ  bit i = not_empty from output buffer i.
REQ-006 bus_stall  input  1  bus is reserved by an unarbitrated source this cycle; no permit may be issued.
REQ-007 permit  output  N_REQ  bit i = data_bus_permit to output buffer i.
REQ-008 bus_valid  output  1  a permit is asserted this cycle, so bus data/tag are driven and consumers sample them.
REQ-009 grant_idx  output  IDX_WIDTH  index of the permitted buffer; 0 when bus_valid=0.
REQ-010 priority_ptr  output  IDX_WIDTH  current round-robin pointer, exported for debug.

Function
REQ-011 permit, bus_valid and grant_idx are combinational from request, bus_stall and priority_ptr; grant latency is zero cycles.
- Buffers drive the tri-state bus in the same cycle.
- Buffers retire the entry at the next posedge.
REQ-012 permit is one-hot or all-zero in every cycle; two bits set at once is a bus conflict and is forbidden.
REQ-013 With bus_stall=0 and request!=0, grant the first set request bit scanning ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1.
REQ-014 With bus_stall=1, or with request=0: permit=0, bus_valid=0, grant_idx=0.
REQ-015 On a posedge where bus_valid=1, priority_ptr <= (grant_idx+1) mod N_REQ; wrap from N_REQ-1 goes to 0.
REQ-016 On a posedge where bus_valid=0, priority_ptr holds.
REQ-017 If N_REQ is not a power of two, the pointer never takes a value >= N_REQ.
REQ-018 Fairness: a requester holding request high is granted within N_REQ non-stalled cycles.
REQ-019 A requester may receive back-to-back grants only when no other request bit is set.
REQ-020 The arbiter is state-light. Its only register is priority_ptr. It does not track buffer occupancy; request is trusted each cycle.
REQ-021 A request bit that drops in the same cycle it would have won is simply not granted; there is no error.

Reset
REQ-022 While reset=0, priority_ptr=0, permit=0, bus_valid=0 and grant_idx=0 asynchronously, regardless of request.
REQ-023 Reset asserted mid-grant removes the permit immediately; after release, arbitration restarts from index 0.
REQ-024 Reset release is synchronous to clk. The first grant may occur in the first cycle after release.

Structure
REQ-025 N_REQ default and IDX_WIDTH derivation live in the shared out-of-order package, alongside the bus tag width.
REQ-026 The rotating scan is one sub-module, rotating_priority_encoder, with these ports:
- inputs: request, ptr
- outputs: one-hot grant, index, valid
REQ-027 cdb_arbiter contains only the pointer register, the stall gating and that instance.

Verification
REQ-028 Reset, then request=4'b0000 for 3 cycles -> permit=0, bus_valid=0, ptr stays 0.
REQ-029 ptr=0, request=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3; ptr after each grant is 1,2,3,0,...
REQ-030 ptr=2, request=4'b0011 -> permit=4'b0001, grant_idx=0; next cycle permit=4'b0010, ptr=1, then 2.
REQ-031 request=4'b1010, bus_stall=1 for 2 cycles then 0 -> no permit and ptr unchanged while stalled; then grant to index 1 (ptr=0) and ptr=2.
REQ-032 Two output buffers attached:
- Buffer 0 is loaded with 3 entries and buffer 1 with 1 entry.
- Required CDB order: buf0, buf1, buf0, buf0.
- Each buffer's not_empty falls when it drains.
- The bus is never multiply driven.
REQ-033 Reset asserted while permit=4'b0100 -> permit=0 in the same cycle without a clock edge; after release ptr=0.
- Assertion held throughout all scenarios: $onehot0(permit) and bus_valid==|permit.
